// File: rtl/sm_wport_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package sm_wport_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int DEFAULT_LOCK_MAX = 8;

    // Index width for n items; never below 1 so single-bit indices stay legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sm_rr_pick.sv
// Combinational N-way rotating priority picker: first set request at or after ptr wins.
module sm_rr_pick
    import sm_wport_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_wport_arbiter.sv
// Round-robin arbiter for the shared register-file write port; writes to $0 are dropped.
// Define SM_WPORT_LOCK_EN to compile in grant locking (LOCKED state, cnt, LOCK_MAX).
module sm_wport_arbiter
    import sm_wport_pkg::*;
#(
    parameter int  N        = 2,
    parameter int  WIDTH    = 32,
    parameter int  AW       = 5,
    parameter int  LOCK_MAX = DEFAULT_LOCK_MAX,
    localparam int IW       = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N-1:0]     req_lock,
    input  logic [N*AW-1:0]  req_addr,
    input  logic [N*WIDTH-1:0] req_data,
    output logic [N-1:0]     req_ready,
    output logic             wp_we,
    output logic [AW-1:0]    wp_addr,
    output logic [WIDTH-1:0] wp_data,
    output logic [IW-1:0]    owner
);

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             wp_we_q, wp_we_d;
    logic [AW-1:0]    wp_addr_q, wp_addr_d;
    logic [WIDTH-1:0] wp_data_q, wp_data_d;

    logic [N-1:0]     pick_req;
    logic [N-1:0]     pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

`ifdef SM_WPORT_LOCK_EN
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // While locked, everyone but the owner is masked out of the picker.
    always_comb begin
        pick_req = req_valid;
        if (state_q == LOCKED) pick_req = req_valid & ({{(N-1){1'b0}}, 1'b1} << owner_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (pick_any && req_lock[pick_idx] && (LOCK_MAX > 1)) begin
                    state_d = LOCKED;
                    cnt_d   = 8'd1;
                end
            end
            LOCKED: begin
                if (!req_valid[owner_q]) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else if (pick_any) begin
                    if (req_lock[owner_q] && (int'(cnt_q) + 1 < LOCK_MAX)) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = (^req_lock) ^ (LOCK_MAX == 0);

    always_comb begin
        pick_req = req_valid;
    end
`endif

    sm_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign req_ready = pick_gnt & {N{rst}};

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        wp_we_d   = 1'b0;
        wp_addr_d = wp_addr_q;
        wp_data_d = wp_data_q;
        if (pick_any) begin
            owner_d = pick_idx;
            ptr_d   = (int'(pick_idx) == N - 1) ? '0 : pick_idx + IW'(1);
            // $0 is hardwired: acknowledge but leave the write port untouched.
            if (sel_addr != '0) begin
                wp_we_d   = 1'b1;
                wp_addr_d = sel_addr;
                wp_data_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            wp_we_q   <= 1'b0;
            wp_addr_q <= '0;
            wp_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            wp_we_q   <= wp_we_d;
            wp_addr_q <= wp_addr_d;
            wp_data_q <= wp_data_d;
        end
    end

    assign wp_we   = wp_we_q;
    assign wp_addr = wp_addr_q;
    assign wp_data = wp_data_q;
    assign owner   = owner_q;

endmodule
